// File: rtl/sc_datamem_io_gen_pkg.sv
// dmem_io_pkg: shared constants and helpers for the sc_datamem_io_gen data
// memory slice.
//   IO_OUT_BASE / IO_IN_BASE / IO_TIMER_OFF : I/O word-offset map
//   byte_merge : combine an old and a new word under a 4-bit byte enable
//   clog2      : ceiling log2 for sizing the RAM index
package dmem_io_pkg;

  localparam int IO_OUT_BASE  = 0;
  localparam int IO_IN_BASE   = 16;
  localparam int IO_TIMER_OFF = 31;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_datamem_io_gen_if.sv
// sc_datamem_io_gen_if: CPU-side data memory bus.
//   addr    : byte address (bits [1:0] ignored)
//   datain  : store data
//   we      : write strobe
//   be      : byte enables, be[i] covers datain[8i+7:8i]
//   dataout : registered read data from the memory
// master = CPU side, slave = memory side.
interface sc_datamem_io_gen_if;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        we;
  logic [3:0]  be;
  logic [31:0] dataout;

  modport master (output addr, output datain, output we, output be, input dataout);
  modport slave  (input addr, input datain, input we, input be, output dataout);
endinterface

// File: rtl/sc_datamem_io_gen_regs.sv
// dmem_io_regs: I/O space of the data memory.
// Holds the output port registers, the double-flop input synchronisers, the
// optional cycle timer and the combinational I/O read mux (pre-edge values).
// Optional feature macro: DMEM_IO_TIMER_EN (cycle timer at offset 31).
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   off          : I/O word offset (addr[6:2])
//   wr_en        : write strobe already qualified with I/O-space select
//   wdata, be    : store data and byte enables
//   rdata        : read value for the current offset (feeds dataout register)
//   out_ports    : registered output ports, port k at [32k+31:32k]
//   in_ports     : asynchronous input ports, port k at [32k+31:32k]
module dmem_io_regs
  import dmem_io_pkg::*;
#(
  parameter int NOUT = 3,
  parameter int NIN  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [4:0]           off,
  input  logic                 wr_en,
  input  logic [31:0]          wdata,
  input  logic [3:0]           be,
  output logic [31:0]          rdata,
  output logic [NOUT*32-1:0]   out_ports,
  input  logic [NIN*32-1:0]    in_ports
);

  logic [NOUT*32-1:0] out_r;
  logic [NIN*32-1:0]  sync1_r;
  logic [NIN*32-1:0]  sync2_r;
  logic [31:0]        rdata_s;

  // Output port registers with byte-enable writes; reset wins over writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_r <= '0;
    end else begin
      for (int k = 0; k < NOUT; k++) begin
        if (wr_en && (off == 5'(IO_OUT_BASE + k))) begin
          out_r[32*k +: 32] <= byte_merge(out_r[32*k +: 32], wdata, be);
        end
      end
    end
  end

  // Two-stage synchroniser for the asynchronous input ports.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= in_ports;
      sync2_r <= sync1_r;
    end
  end

`ifdef DMEM_IO_TIMER_EN
  logic [31:0] timer_r;

  // Free-running cycle timer; a write loads enabled bytes instead of counting.
  always_ff @(posedge clock) begin
    if (reset) begin
      timer_r <= 32'h0000_0000;
    end else if (wr_en && (off == 5'(IO_TIMER_OFF))) begin
      timer_r <= byte_merge(timer_r, wdata, be);
    end else begin
      timer_r <= timer_r + 32'h0000_0001;
    end
  end
`endif

  // I/O read mux; unmapped offsets read zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    for (int k = 0; k < NOUT; k++) begin
      if (off == 5'(IO_OUT_BASE + k)) begin
        rdata_s = out_r[32*k +: 32];
      end else begin
        rdata_s = rdata_s;
      end
    end
    for (int k = 0; k < NIN; k++) begin
      if (off == 5'(IO_IN_BASE + k)) begin
        rdata_s = sync2_r[32*k +: 32];
      end else begin
        rdata_s = rdata_s;
      end
    end
`ifdef DMEM_IO_TIMER_EN
    if (off == 5'(IO_TIMER_OFF)) begin
      rdata_s = timer_r;
    end else begin
      rdata_s = rdata_s;
    end
`endif
  end

  assign rdata     = rdata_s;
  assign out_ports = out_r;

endmodule

// File: rtl/sc_datamem_io_gen.sv
// sc_datamem_io_gen: parametrised data memory with memory-mapped I/O for the
// single-cycle computer. Holds the RAM array, the RAM/I/O decode and the
// final dataout register; I/O space lives in dmem_io_regs.
// Optional feature macro: DMEM_IO_TIMER_EN (cycle timer at I/O offset 31).
// Parameters: MEM_WORDS (RAM depth, power of two, >= 2), IO_BIT (I/O select
// address bit), NOUT (output ports 1..16), NIN (input ports 1..15).
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus          : CPU bus (addr, datain, we, be, dataout)
//   out_ports    : output port registers, port k at [32k+31:32k]
//   in_ports     : asynchronous input ports, port k at [32k+31:32k]
module sc_datamem_io_gen
  import dmem_io_pkg::*;
#(
  parameter int MEM_WORDS = 32,
  parameter int IO_BIT    = 7,
  parameter int NOUT      = 3,
  parameter int NIN       = 2
) (
  input  logic                clock,
  input  logic                reset,
  sc_datamem_io_gen_if.slave  bus,
  output logic [NOUT*32-1:0]  out_ports,
  input  logic [NIN*32-1:0]   in_ports
);

  localparam int AW = clog2(MEM_WORDS);

  logic [31:0]   ram_r [MEM_WORDS];
  logic [31:0]   dataout_r;
  logic [AW-1:0] ram_idx_s;
  logic          io_sel_s;
  logic [4:0]    io_off_s;
  logic [31:0]   io_rdata_s;
  logic          ram_we_s;
  logic          unused_addr_s;

  assign io_sel_s  = bus.addr[IO_BIT];
  assign io_off_s  = bus.addr[6:2];
  // Upper RAM-space address bits are ignored, so RAM aliases across them.
  assign ram_idx_s = bus.addr[2 +: AW];
  assign ram_we_s  = bus.we && !io_sel_s && !reset;
  assign unused_addr_s = ^bus.addr;

  // RAM array: byte-enable writes, no reset of contents.
  always_ff @(posedge clock) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= byte_merge(ram_r[ram_idx_s], bus.datain, bus.be);
    end
  end

  dmem_io_regs #(
    .NOUT (NOUT),
    .NIN  (NIN)
  ) u_io_regs (
    .clock     (clock),
    .reset     (reset),
    .off       (io_off_s),
    .wr_en     (bus.we && io_sel_s),
    .wdata     (bus.datain),
    .be        (bus.be),
    .rdata     (io_rdata_s),
    .out_ports (out_ports),
    .in_ports  (in_ports)
  );

  // Read every cycle from pre-edge contents, giving read-before-write.
  always_ff @(posedge clock) begin
    if (reset) begin
      dataout_r <= 32'h0000_0000;
    end else if (io_sel_s) begin
      dataout_r <= io_rdata_s;
    end else begin
      dataout_r <= ram_r[ram_idx_s];
    end
  end

  assign bus.dataout = dataout_r;

endmodule

// File: tb/tb_sc_datamem_io_gen.sv
// tb_sc_datamem_io_gen: directed self-checking bench for sc_datamem_io_gen
// with default parameters (32 words, IO_BIT 7, 3 outputs, 2 inputs).
module tb_sc_datamem_io_gen;

  logic         clock;
  logic         reset;
  logic [95:0]  out_ports;
  logic [63:0]  in_ports;
  int           chk_cnt;
  int           err_cnt;

  sc_datamem_io_gen_if bus ();

  sc_datamem_io_gen dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .out_ports (out_ports),
    .in_ports  (in_ports)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present one bus cycle, then sample 1 ns after the rising edge.
  task automatic access(input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [3:0] b);
    bus.addr   = a;
    bus.datain = d;
    bus.we     = w;
    bus.be     = b;
    @(posedge clock);
    #1;
    bus.we = 1'b0;
  endtask

  initial begin
    chk_cnt    = 0;
    err_cnt    = 0;
    reset      = 1'b1;
    in_ports   = 64'h0;
    bus.addr   = 32'h0;
    bus.datain = 32'h0;
    bus.we     = 1'b0;
    bus.be     = 4'h0;

    // Reset state
    access(32'h0000_0000, 32'h0, 1'b0, 4'h0);
    access(32'h0000_0000, 32'h0, 1'b0, 4'h0);
    check("rst_dataout", bus.dataout, 32'h0);
    check("rst_port0", out_ports[31:0], 32'h0);
    check("rst_port1", out_ports[63:32], 32'h0);
    check("rst_port2", out_ports[95:64], 32'h0);
    reset = 1'b0;
    access(32'h0000_0080, 32'h0, 1'b0, 4'h0);
    check("rd_out0_init", bus.dataout, 32'h0);
    access(32'h0000_0088, 32'h0, 1'b0, 4'h0);
    check("rd_out2_init", bus.dataout, 32'h0);
    access(32'h0000_00C4, 32'h0, 1'b0, 4'h0);
    check("rd_in1_init", bus.dataout, 32'h0);
`ifndef DMEM_IO_TIMER_EN
    access(32'h0000_00FC, 32'h0, 1'b0, 4'h0);
    check("rd_timer_off", bus.dataout, 32'h0);
`endif

    // RAM byte-enable writes and read-before-write
    access(32'h0000_0004, 32'hDEAD_BEEF, 1'b1, 4'b1111);
    access(32'h0000_0004, 32'h0000_00AA, 1'b1, 4'b0001);
    check("ram_rbw_old", bus.dataout, 32'hDEAD_BEEF);
    access(32'h0000_0004, 32'h0, 1'b0, 4'h0);
    check("ram_be0001", bus.dataout, 32'hDEAD_BEAA);
    access(32'h0000_0104, 32'h0, 1'b0, 4'h0);
    check("ram_alias", bus.dataout, 32'hDEAD_BEAA);
    access(32'h0000_0004, 32'h1122_3344, 1'b1, 4'b0110);
    access(32'h0000_0004, 32'h0, 1'b0, 4'h0);
    check("ram_be0110", bus.dataout, 32'hDE22_33AA);
    access(32'h0000_0008, 32'h0BAD_F00D, 1'b1, 4'b1111);
    access(32'h0000_0004, 32'h0, 1'b0, 4'h0);
    check("ram_other_word", bus.dataout, 32'hDE22_33AA);
    access(32'h0000_0008, 32'h0, 1'b0, 4'h0);
    check("ram_word2", bus.dataout, 32'h0BAD_F00D);

    // Output registers
    access(32'h0000_0080, 32'h1234_5678, 1'b1, 4'b1111);
    check("port0_wr", out_ports[31:0], 32'h1234_5678);
    access(32'h0000_0084, 32'h0000_0055, 1'b1, 4'b1111);
    check("port1_wr", out_ports[63:32], 32'h0000_0055);
    access(32'h0000_0088, 32'hAB00_0000, 1'b1, 4'b1000);
    check("port2_be1000", out_ports[95:64], 32'hAB00_0000);
    access(32'h0000_0084, 32'h0000_0099, 1'b1, 4'b1111);
    check("port1_rbw_old", bus.dataout, 32'h0000_0055);
    check("port1_new", out_ports[63:32], 32'h0000_0099);
    access(32'h0000_00C0, 32'hFFFF_FFFF, 1'b1, 4'b1111);
    access(32'h0000_00C0, 32'h0, 1'b0, 4'h0);
    check("in0_wr_ignored", bus.dataout, 32'h0);
    access(32'h0000_008C, 32'hFFFF_FFFF, 1'b1, 4'b1111);
    access(32'h0000_008C, 32'h0, 1'b0, 4'h0);
    check("unmapped_off3", bus.dataout, 32'h0);
    check("port0_keep", out_ports[31:0], 32'h1234_5678);
    access(32'h0000_0080, 32'h0, 1'b0, 4'h0);
    check("rd_port0", bus.dataout, 32'h1234_5678);

    // Input synchroniser latency: change lands on the third edge
    in_ports[63:32] = 32'hCAFE_0001;
    access(32'h0000_00C4, 32'h0, 1'b0, 4'h0);
    check("in1_edge1", bus.dataout, 32'h0);
    access(32'h0000_00C4, 32'h0, 1'b0, 4'h0);
    check("in1_edge2", bus.dataout, 32'h0);
    access(32'h0000_00C4, 32'h0, 1'b0, 4'h0);
    check("in1_edge3", bus.dataout, 32'hCAFE_0001);
    access(32'h0000_00C0, 32'h0, 1'b0, 4'h0);
    check("in0_still0", bus.dataout, 32'h0);
    access(32'h0000_00C8, 32'h0, 1'b0, 4'h0);
    check("unmapped_off18", bus.dataout, 32'h0);

    // Timer
    access(32'h0000_00FC, 32'hFFFF_FFFE, 1'b1, 4'b1111);
`ifdef DMEM_IO_TIMER_EN
    access(32'h0000_00FC, 32'h0, 1'b0, 4'h0);
    check("timer_t0", bus.dataout, 32'hFFFF_FFFE);
    access(32'h0000_00FC, 32'h0, 1'b0, 4'h0);
    check("timer_t1", bus.dataout, 32'hFFFF_FFFF);
    access(32'h0000_00FC, 32'h0, 1'b0, 4'h0);
    check("timer_wrap", bus.dataout, 32'h0000_0000);
`else
    access(32'h0000_00FC, 32'h0, 1'b0, 4'h0);
    check("timer_absent", bus.dataout, 32'h0);
`endif

    // Reset wins over a simultaneous write
    reset = 1'b1;
    access(32'h0000_0080, 32'h0000_0077, 1'b1, 4'b1111);
    check("rstwr_port0", out_ports[31:0], 32'h0);
    check("rstwr_dataout", bus.dataout, 32'h0);
    access(32'h0000_0004, 32'h0000_0077, 1'b1, 4'b1111);
    check("rstwr_port1", out_ports[63:32], 32'h0);
    reset = 1'b0;
    access(32'h0000_0004, 32'h0, 1'b0, 4'h0);
    check("ram_kept_thru_rst", bus.dataout, 32'hDE22_33AA);
    access(32'h0000_0080, 32'h0, 1'b0, 4'h0);
    check("port0_after_rst", bus.dataout, 32'h0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sc_datamem_io_gen.md
# sc_datamem_io_gen

Parametrised data memory with memory-mapped I/O for the single-cycle computer. It replaces the fixed 32-word, 3-output/2-input data memory. It adds:
- configurable memory depth and output/input port counts,
- byte-enable writes,
- registered one-cycle reads,
- double-flop input synchronisers,
- an optional free-running cycle timer in I/O space.

It sits between the CPU's ALU result/store-data path and the board-level LED/switch ports.

## Interface
Parameters:
- MEM_WORDS, 32, data RAM depth in 32-bit words; power of two; MEM_WORDS*4 <= 2**IO_BIT
- IO_BIT, 7, byte-address bit selecting I/O space (1) vs RAM (0)
- NOUT, 3, number of 32-bit output port registers, 1..16
- NIN, 2, number of 32-bit input ports, 1..15

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- addr  in  32  byte address; bits [1:0] ignored
- datain  in  32  store data
- we  in  1  write strobe, sampled at rising edge
- be  in  4  byte enables for writes; be[i] covers datain[8i+7:8i]
- dataout  out  32  registered read data
- out_ports  out  NOUT*32  output port registers; port k at [32k+31:32k]
- in_ports  in  NIN*32  asynchronous input ports; port k at [32k+31:32k]

## Operation
- Decode: addr[IO_BIT]=0 selects RAM; =1 selects I/O. The I/O word offset is off = addr[6:2].
- RAM index is addr[2 +: clog2(MEM_WORDS)]. Upper RAM-space bits alias.
- RAM write: we=1 updates only the enabled bytes.
- RAM contents are not reset.
- I/O map:
  - off 0..NOUT-1: output registers, read/write, byte enables apply.
  - off 16..16+NIN-1: synchronised inputs, read-only; writes ignored.
  - off 31: timer (see Configuration).
  - Any other offset reads 0; writes to it are ignored.
- Input path: sync1 <= in_ports, then sync2 <= sync1, every cycle. Reads return sync2.
- Every access is a read: dataout is loaded every cycle from the selected source, whether or not we is high.
- Read-during-write to the same location returns the old value (read-before-write), for both RAM and output registers.
- Reset values:
  - dataout = 0, out_ports = 0, sync1 = 0, sync2 = 0, timer = 0.
  - While reset=1, writes are suppressed (RAM and I/O) and dataout holds 0.

## Timing
- Read latency is 1 cycle: addr presented before edge N gives dataout valid after edge N, stable until edge N+1.
- Write takes effect at edge N. The same address read at N+1 returns the new value.
- out_ports changes directly after the write edge, with no further delay.
- Input latency: an in_ports change before edge N is in sync2 after edge N+1. A read addressed at edge N+2 shows it after N+2.
- Reset asserted during a write cycle: reset wins; neither RAM nor the registers change.

## Configuration
- DMEM_IO_TIMER_EN defined:
  - Off 31 holds a 32-bit counter that increments every non-reset cycle and wraps 0xFFFFFFFF -> 0.
  - A write to off 31 loads the enabled bytes of datain for that cycle, instead of incrementing.
  - A read returns the pre-edge value.
- Not defined: no counter is built; off 31 reads 0 and writes are ignored.

## Structure
- Package dmem_io_pkg holds:
  - constants IO_OUT_BASE=0, IO_IN_BASE=16, IO_TIMER_OFF=31;
  - byte-merge function (old word, new word, be);
  - clog2 helper.
- One sub-module, dmem_io_regs, contains the output registers, input synchronisers, timer and I/O read mux. The top level holds the RAM array, decode and the final dataout register.

## Test plan
- Reset, then read RAM and all I/O offsets -> dataout=0, out_ports all 0.
- Write 0xDEADBEEF to byte addr 0x04 with be=4'b1111, then write 0x000000AA with be=4'b0001 -> read 0x04 returns 0xDEADBEAA one cycle after the address.
- Write 0x12345678 to 0x80 (off 0) and 0x55 to 0x84 (off 1) -> out_ports port0=0x12345678, port1=0x55 after the write edge; write to 0xC0 (off 16) ignored.
- Drive in_ports port1=0xCAFE0001 and read 0xC4 every cycle -> value appears exactly 3 edges after the change; earlier reads show the old value.
- With DMEM_IO_TIMER_EN: write 0xFFFFFFFE to 0xFC, then read 0xFC on the next three cycles -> 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000. Without the macro -> 0.
- Assert reset in the same cycle as a write of 0x77 to 0x80 -> out_ports port0 stays 0 and dataout=0.
